varredura_display_bcd: RTL



---
 rtl/varredura_display_bcd.sv | 137 +++++++++++++
 1 files changed

// File: rtl/varredura_display_bcd.sv
`default_nettype none
// ============================================================================
// Module   : varredura_display_bcd
// Brief    : Latches a BCD triple and scans it onto a 3-digit common-anode
//            7-segment display. Define LEADING_ZERO_BLANK_EN to blank leading
//            zeros on the centenas/dezenas digits.
// Revision : 1.0 - initial release
// ============================================================================
module varredura_display_bcd #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] bcd_centenas,
  input  logic [3:0] bcd_dezenas,
  input  logic [3:0] bcd_unidades,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
  localparam logic [6:0]       c_seg_off = 7'b1111111;

  typedef enum logic [1:0] {
    UNI = 2'd0,
    DEZ = 2'd1,
    CEN = 2'd2
  } idx_t;

  idx_t             r_idx;
  idx_t             w_idx_next;
  logic [CNT_W-1:0] r_presc;
  logic [CNT_W-1:0] w_presc_next;
  logic             w_adv;
  logic [3:0]       r_cen;
  logic [3:0]       r_dez;
  logic [3:0]       r_uni;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [2:0]       w_an_next;
  logic [6:0]       w_seg_next;
  logic             w_tick_next;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_idx      <= UNI;
      r_cen      <= 4'd0;
      r_dez      <= 4'd0;
      r_uni      <= 4'd0;
      an         <= 3'b111;
      seg        <= c_seg_off;
      frame_tick <= 1'b0;
    end else begin
      r_presc    <= w_presc_next;
      r_idx      <= w_idx_next;
      if (load) begin
        r_cen <= bcd_centenas;
        r_dez <= bcd_dezenas;
        r_uni <= bcd_unidades;
      end
      an         <= w_an_next;
      seg        <= w_seg_next;
      frame_tick <= w_tick_next;
    end
  end

  always_comb begin
    w_adv        = (r_presc == c_last);
    w_presc_next = r_presc + c_one;
    w_idx_next   = r_idx;
    w_an_next    = 3'b111;
    w_digit      = 4'd0;
    w_blank      = 1'b0;

    if (w_adv) begin
      w_presc_next = '0;
      case (r_idx)
        UNI:     w_idx_next = DEZ;
        DEZ:     w_idx_next = CEN;
        default: w_idx_next = UNI;
      endcase
    end

    case (r_idx)
      UNI: begin
        w_an_next = 3'b110;
        w_digit   = r_uni;
      end
      DEZ: begin
        w_an_next = 3'b101;
        w_digit   = r_dez;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank   = (r_cen == 4'd0) && (r_dez == 4'd0);
`endif
      end
      CEN: begin
        w_an_next = 3'b011;
        w_digit   = r_cen;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank   = (r_cen == 4'd0);
`endif
      end
      default: begin
        // Unreachable encoding: keep every digit dark until it recovers.
        w_an_next = 3'b111;
        w_blank   = 1'b1;
      end
    endcase

    w_seg_next  = w_blank ? c_seg_off : decode(w_digit);
    w_tick_next = w_adv && (r_idx == CEN);
  end

endmodule
`default_nettype wire
